// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit ripple-carry adder across NIBBLES clock cycles.
// The carry between slices is held in a register, and the final result is presented with a one-cycle done pulse.

module rca4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_carry
);
  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end
  endgenerate

  assign o_carry = w_c[4];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [4*NIBBLES-1:0] i_a,
  input  logic [4*NIBBLES-1:0] i_b,
  input  logic                 i_cin,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [4*NIBBLES-1:0] o_sum,
  output logic                 o_cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = 5;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_a_sh;
  logic [W-1:0]  r_b_sh;
  logic [W-1:0]  r_psum;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          r_done;

  logic          w_busy;
  logic          w_accept;
  logic          w_last;
  logic [3:0]    w_rca_sum;
  logic          w_rca_cout;
  logic [W-1:0]  w_psum_next;

  rca4 u_rca (
    .i_a     (r_a_sh[3:0]),
    .i_b     (r_b_sh[3:0]),
    .i_cin   (r_carry),
    .o_sum   (w_rca_sum),
    .o_carry (w_rca_cout)
  );

  // The new nibble enters at the top, so after NIBBLES shifts slice 0 lands in bits [3:0].
  assign w_psum_next = (r_psum >> 4) | (W'(w_rca_sum) << (W - 4));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_RUN;
      S_RUN:   if (w_last)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state == S_RUN);
    w_accept = (r_state == S_IDLE) && i_start;
    w_last   = w_busy && (r_cnt == LAST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a_sh  <= i_a;
        r_b_sh  <= i_b;
        r_carry <= i_cin;
        r_cnt   <= '0;
      end else if (w_busy) begin
        r_a_sh  <= r_a_sh >> 4;
        r_b_sh  <= r_b_sh >> 4;
        r_psum  <= w_psum_next;
        r_carry <= w_rca_cout;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_sum  <= w_psum_next;
          r_cout <= w_rca_cout;
        end
      end
    end
  end

  assign o_busy = w_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder. It drives a 16-bit instance and a 4-bit instance,
// and compares every result with plain A+B+CIN arithmetic.

module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start4 = 1'b0, cin4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        busy4, done4, cout4;
  logic [15:0] sum4;

  logic        start1 = 1'b0, cin1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic        busy1, done1, cout1;
  logic [3:0]  sum1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_a(a4), .i_b(b4), .i_cin(cin4),
    .o_busy(busy4), .o_done(done4), .o_sum(sum4), .o_cout(cout4)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_a(a1), .i_b(b1), .i_cin(cin1),
    .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_cout(cout1)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Called at a falling edge. Returns at the falling edge where done is seen.
  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input bit noise, input bit hold_start, input string name);
    logic [16:0] exp;
    int edges;
    int busy_cnt;
    bit seen;
    exp = 17'(a) + 17'(b) + 17'(cin);
    a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = hold_start;
    edges = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && edges < 20) begin
      @(negedge clk);
      if (done4) begin
        seen = 1'b1;
      end else begin
        if (busy4) busy_cnt++;
        a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
        start4 = hold_start ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
        @(posedge clk);
        edges++;
      end
    end
    start4 = hold_start;
    check({name, " latency"}, 64'(edges), 64'd4);
    check({name, " busy cycles"}, 64'(busy_cnt), 64'd4);
    check({name, " busy in done cycle"}, 64'(busy4), 64'd0);
    check({name, " sum"}, 64'(sum4), 64'(exp[15:0]));
    check({name, " cout"}, 64'(cout4), 64'(exp[16]));
    $display("op %s: %h + %h + %0d -> sum=%h cout=%0d edges=%0d", name, a, b, cin, sum4, cout4, edges);
  endtask

  task automatic idle_after(input string name, input logic [15:0] esum, input logic ecout);
    @(negedge clk);
    check({name, " done cleared"}, 64'(done4), 64'd0);
    check({name, " sum held"}, 64'({cout4, sum4}), 64'({ecout, esum}));
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic cin, input string name);
    logic [4:0] exp;
    exp = 5'(a) + 5'(b) + 5'(cin);
    a1 = a; b1 = b; cin1 = cin; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
    @(negedge clk);
    check({name, " busy"}, 64'({busy1, done1}), 64'b10);
    @(negedge clk);
    check({name, " done"}, 64'({busy1, done1}), 64'b01);
    check({name, " result"}, 64'({cout1, sum1}), 64'(exp));
    $display("n1 op %s: %h + %h + %0d -> sum=%h cout=%0d", name, a, b, cin, sum1, cout1);
    @(negedge clk);
    check({name, " done cleared"}, 64'(done1), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b1, sum: 16'h5556, cout: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
    vecs[2] = '{a: 16'hDDDD, b: 16'hDDDD, cin: 1'b1, sum: 16'hBBBB, cout: 1'b1};
    vecs[3] = '{a: 16'h1234, b: 16'h4321, cin: 1'b1, sum: 16'h5556, cout: 1'b0};

    #12;
    check("reset outputs", 64'({busy4, done4, cout4, sum4}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Spec vectors, with START pulses injected while busy.
    for (int i = 0; i < 4; i++) begin
      run4(vecs[i].a, vecs[i].b, vecs[i].cin, (i % 2) == 1, 1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table", i), 64'({cout4, sum4}), 64'({vecs[i].cout, vecs[i].sum}));
      idle_after($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout);
    end

    // Hold check: free-running inputs with START low must not disturb the result.
    for (int k = 0; k < 10; k++) begin
      a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
      @(negedge clk);
      check($sformatf("hold %0d", k), 64'({done4, busy4, cout4, sum4}), 64'({2'b00, 1'b0, 16'h5556}));
    end

    // START held high: the second operation is accepted in the DONE cycle.
    run4(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, "b2b0");
    run4(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, "b2b1");
    idle_after("b2b1", 16'h0100, 1'b0);

    // Reset asserted after two slices of 0xFFFF + 0xFFFF.
    a4 = 16'hFFFF; b4 = 16'hFFFF; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun reset", 64'({busy4, done4, cout4, sum4}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("post reset idle %0d", k), 64'({busy4, done4, cout4, sum4}), 64'd0);
    end
    run4(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, "after_reset");
    idle_after("after_reset", 16'h0007, 1'b0);

    // Randomized operations against A+B+CIN.
    for (int k = 0; k < 20; k++) begin
      logic [15:0] ra, rb;
      logic rc;
      logic [16:0] e;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      if (k == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; end
      e = 17'(ra) + 17'(rb) + 17'(rc);
      run4(ra, rb, rc, 1'b1, 1'b0, $sformatf("rnd%0d", k));
      idle_after($sformatf("rnd%0d", k), e[15:0], e[16]);
    end

    // Single-slice instance.
    run1(4'hD, 4'hD, 1'b1, "n1_spec");
    for (int k = 0; k < 6; k++)
      run1(4'($urandom), 4'($urandom), 1'($urandom), $sformatf("n1_rnd%0d", k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
